mult16_shift_add: RTL

- Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier.
- Sits directly upstream of the combinational 16-bit ripple adder stage: each cycle it drives one operand pair into the adder and consumes the 17-bit sum (16 sum bits plus carry-out).
- One partial-product step per clock, with a start/busy/done handshake to the control logic.

---
 rtl/mult16_shift_add.sv | 72 +++++++
 1 files changed

// File: rtl/mult16_shift_add.sv
// mult16_shift_add: sequential unsigned 16x16->32 shift-and-add multiplier
// Ports: clk, rst_n (sync active-low); start/a/b request a multiply;
// busy/done/product report status and result; adder_a/adder_b/adder_cin
// drive the external 16-bit adder and adder_sum returns {carry, sum}.
module mult16_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  output logic               adder_cin,
  input  logic [WIDTH:0]     adder_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q, p_d, product_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  // keep the carry: {sum, P[15:0]} shifted right by one
  assign p_d       = {adder_sum, p_q[WIDTH-1:1]};
  assign adder_a   = p_q[2*WIDTH-1:WIDTH];
  assign adder_b   = p_q[0] ? m_q : '0;
  assign adder_cin = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          m_q     <= a;
          p_q     <= {{WIDTH{1'b0}}, b};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            product_q <= p_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
